// File: rtl/ram_banked_pkg.sv
// Shared types and helpers for the banked SRAM controller.
// rsp_t carries one response; its data width is fixed by RSP_DW.
package ram_banked_pkg;

  localparam int unsigned RSP_DW = 32;

  typedef struct packed {
    logic [RSP_DW-1:0] rdata;
    logic              err;
    logic              write;
  } rsp_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Bank index is whatever sits above the in-bank word address; at most 8 banks.
  function automatic logic [3:0] bank_idx(input logic [31:0] addr, input int unsigned bank_aw);
    logic [31:0] sh;
    sh = addr >> bank_aw;
    return sh[3:0];
  endfunction

endpackage

// File: rtl/ram_rsp_skid.sv
// Two-entry in-order response FIFO holding responses the consumer has not yet taken.
module ram_rsp_skid
  import ram_banked_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  rsp_t       data_i,
  input  logic       pop_i,
  output rsp_t       head_o,
  output logic [1:0] count_o
);

  rsp_t       ent0_q, ent0_d, ent1_q, ent1_d;
  logic       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push_s, do_pop_s;

  // Pointer, count and entry next-state; a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    do_pop_s  = pop_i && (cnt_q != 2'd0);
    do_push_s = push_i && ((cnt_q != 2'd2) || do_pop_s);
    ent0_d    = ent0_q;
    ent1_d    = ent1_q;
    if (do_push_s && !wr_ptr_q) begin
      ent0_d = data_i;
    end else if (do_push_s) begin
      ent1_d = data_i;
    end else begin
      ent0_d = ent0_q;
    end
    rd_ptr_d = do_pop_s  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = do_push_s ? ~wr_ptr_q : wr_ptr_q;
    cnt_d    = cnt_q + 2'(do_push_s) - 2'(do_pop_s);
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = rd_ptr_q ? ent1_q : ent0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/ram_banked_ctrl.sv
// Banked SRAM controller: one valid/ready request port in front of NUM_BANKS
// single-cycle macros, in-order responses with a 2-entry skid for backpressure.
module ram_banked_ctrl
  import ram_banked_pkg::*;
#(
  parameter  int unsigned NUM_BANKS = 4,
  parameter  int unsigned BANK_AW   = 10,
  parameter  int unsigned DW        = RSP_DW,
  localparam int unsigned AW        = BANK_AW + clog2(NUM_BANKS),
  localparam int unsigned NB_W      = DW / 8
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NB_W-1:0]         req_we,
  input  logic [AW-1:0]           req_addr,
  input  logic [DW-1:0]           req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_write,
  output logic [NUM_BANKS-1:0]    bank_en,
  output logic [NB_W-1:0]         bank_we,
  output logic [BANK_AW-1:0]      bank_a,
  output logic [DW-1:0]           bank_di,
  input  logic [NUM_BANKS*DW-1:0] bank_do
);

  localparam logic [3:0] NB = 4'(NUM_BANKS);

  logic          accept_s, err_s, is_write_s;
  logic [3:0]    bank_s;
  logic          infl_valid_q, infl_valid_d, infl_err_q, infl_err_d, infl_write_q, infl_write_d;
  logic [3:0]    infl_bank_q, infl_bank_d;
  logic          req_ready_q, req_ready_d;
  logic [DW-1:0] sel_do_s;
  rsp_t          cand_s, skid_head_s, rsp_s;
  logic          rsp_valid_s, skid_push_s, skid_pop_s;
  logic [1:0]    skid_cnt_s, skid_cnt_next_s;

  // Request decode and macro drive; reset low blocks any enable even though req_ready resets high.
  always_comb begin
    accept_s   = req_valid && req_ready_q && RESETn;
    bank_s     = bank_idx(32'(req_addr), BANK_AW);
    err_s      = (bank_s >= NB);
    is_write_s = |req_we;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_en[i] = accept_s && !err_s && (bank_s == 4'(i));
    end
    bank_we = accept_s ? req_we : '0;
    bank_a  = req_addr[BANK_AW-1:0];
    bank_di = req_wdata;
  end

  // Inflight capture of the accepted request's routing info.
  always_comb begin
    infl_valid_d = accept_s;
    if (accept_s) begin
      infl_bank_d  = bank_s;
      infl_err_d   = err_s;
      infl_write_d = is_write_s;
    end else begin
      infl_bank_d  = infl_bank_q;
      infl_err_d   = infl_err_q;
      infl_write_d = infl_write_q;
    end
  end

  // Read mux steered by the registered bank, so macro outputs only matter the cycle after access.
  always_comb begin
    sel_do_s = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      sel_do_s = sel_do_s | (bank_do[i*DW +: DW] & {DW{infl_bank_q == 4'(i)}});
    end
    cand_s.rdata = (infl_err_q || infl_write_q) ? '0 : sel_do_s;
    cand_s.err   = infl_err_q;
    cand_s.write = infl_write_q;
  end

  // Response selection (skid first for ordering), skid push/pop, and next req_ready.
  always_comb begin
    if (skid_cnt_s != 2'd0) begin
      rsp_s       = skid_head_s;
      rsp_valid_s = 1'b1;
    end else if (infl_valid_q) begin
      rsp_s       = cand_s;
      rsp_valid_s = 1'b1;
    end else begin
      rsp_s       = '0;
      rsp_valid_s = 1'b0;
    end
    skid_pop_s      = (skid_cnt_s != 2'd0) && rsp_ready;
    skid_push_s     = infl_valid_q && !((skid_cnt_s == 2'd0) && rsp_ready);
    skid_cnt_next_s = skid_cnt_s + 2'(skid_push_s) - 2'(skid_pop_s);
    req_ready_d     = (3'(accept_s) + 3'(skid_cnt_next_s)) < 3'd2;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      infl_valid_q <= 1'b0;
      infl_bank_q  <= 4'd0;
      infl_err_q   <= 1'b0;
      infl_write_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      infl_valid_q <= infl_valid_d;
      infl_bank_q  <= infl_bank_d;
      infl_err_q   <= infl_err_d;
      infl_write_q <= infl_write_d;
      req_ready_q  <= req_ready_d;
    end
  end

  ram_rsp_skid u_skid (
    .clk_i   (CLK),
    .rst_ni  (RESETn),
    .push_i  (skid_push_s),
    .data_i  (cand_s),
    .pop_i   (skid_pop_s),
    .head_o  (skid_head_s),
    .count_o (skid_cnt_s)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_s;
  assign rsp_rdata = rsp_s.rdata;
  assign rsp_err   = rsp_s.err;
  assign rsp_write = rsp_s.write;

endmodule

// File: tb/tb_ram_banked_ctrl.sv
// Directed bench for ram_banked_ctrl: 4-bank and 3-bank instances with behavioural
// macros, a reference memory and per-instance response scoreboards.
module tb_ram_banked_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid4, req_ready4, rsp_valid4, rsp_ready4, rsp_err4, rsp_write4;
  logic [3:0]   req_we4, bank_we4, bank_en4;
  logic [11:0]  req_addr4;
  logic [31:0]  req_wdata4, rsp_rdata4, bank_di4;
  logic [9:0]   bank_a4;
  logic [127:0] bank_do4 = '0;

  logic         req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3, rsp_write3;
  logic [3:0]   req_we3, bank_we3;
  logic [2:0]   bank_en3;
  logic [11:0]  req_addr3;
  logic [31:0]  req_wdata3, rsp_rdata3, bank_di3;
  logic [9:0]   bank_a3;
  logic [95:0]  bank_do3 = '0;

  ram_banked_ctrl #(.NUM_BANKS(4), .BANK_AW(10), .DW(32)) u_dut4 (
    .CLK(clk), .RESETn(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_we(req_we4), .req_addr(req_addr4), .req_wdata(req_wdata4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_rdata(rsp_rdata4),
    .rsp_err(rsp_err4), .rsp_write(rsp_write4), .bank_en(bank_en4), .bank_we(bank_we4),
    .bank_a(bank_a4), .bank_di(bank_di4), .bank_do(bank_do4)
  );

  ram_banked_ctrl #(.NUM_BANKS(3), .BANK_AW(10), .DW(32)) u_dut3 (
    .CLK(clk), .RESETn(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we3), .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .rsp_write(rsp_write3), .bank_en(bank_en3), .bank_we(bank_we3),
    .bank_a(bank_a3), .bank_di(bank_di3), .bank_do(bank_do3)
  );

  logic [31:0] mem4 [4][1024];
  logic [31:0] ref4 [4][1024];
  logic [31:0] mem3 [3][1024];
  logic [31:0] ref3 [3][1024];

  function automatic logic [31:0] init_val(input int b, input int a);
    return 32'hA500_0000 | (32'(b) << 16) | 32'(a);
  endfunction

  // Behavioural macros: byte-masked write, registered write-through read, output held when idle.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_en4[b]) begin
        for (int y = 0; y < 4; y++) if (bank_we4[y]) mem4[b][bank_a4][8*y +: 8] = bank_di4[8*y +: 8];
        bank_do4[b*32 +: 32] <= mem4[b][bank_a4];
      end
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (bank_en3[b]) begin
        for (int y = 0; y < 4; y++) if (bank_we3[y]) mem3[b][bank_a3][8*y +: 8] = bank_di3[8*y +: 8];
        bank_do3[b*32 +: 32] <= mem3[b][bank_a3];
      end
    end
  end

  int   total = 0;
  int   bad = 0;
  exp_t q4[$];
  exp_t q3[$];
  bit   acc4, acc3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge score handshakes due at the next rising edge, then step past it.
  task automatic tick();
    exp_t        e;
    logic [1:0]  b;
    logic [9:0]  a;
    logic [31:0] w;
    @(negedge clk);
    acc4 = 1'b0;
    acc3 = 1'b0;
    if (rst_n && rsp_valid4 && rsp_ready4) begin
      if (q4.size() == 0) chk("rsp4_unexpected", 64'(q4.size()), 64'd1);
      else begin
        e = q4.pop_front();
        chk("rsp4_rdata", 64'(rsp_rdata4), 64'(e.rdata));
        chk("rsp4_err", 64'(rsp_err4), 64'(e.err));
        chk("rsp4_write", 64'(rsp_write4), 64'(e.wr));
      end
    end
    if (rst_n && req_valid4 && req_ready4) begin
      acc4 = 1'b1;
      b = req_addr4[11:10];
      a = req_addr4[9:0];
      chk("bank_en4", 64'(bank_en4), 64'(4'b0001 << b));
      chk("bank_we4", 64'(bank_we4), 64'(req_we4));
      if (req_we4 == 4'd0) begin
        e.rdata = ref4[b][a]; e.err = 1'b0; e.wr = 1'b0;
      end else begin
        w = ref4[b][a];
        for (int y = 0; y < 4; y++) if (req_we4[y]) w[8*y +: 8] = req_wdata4[8*y +: 8];
        ref4[b][a] = w;
        e.rdata = 32'd0; e.err = 1'b0; e.wr = 1'b1;
      end
      q4.push_back(e);
    end else chk("bank_en4_idle", 64'(bank_en4), 64'd0);
    if (rst_n && rsp_valid3 && rsp_ready3) begin
      if (q3.size() == 0) chk("rsp3_unexpected", 64'(q3.size()), 64'd1);
      else begin
        e = q3.pop_front();
        chk("rsp3_rdata", 64'(rsp_rdata3), 64'(e.rdata));
        chk("rsp3_err", 64'(rsp_err3), 64'(e.err));
      end
    end
    if (rst_n && req_valid3 && req_ready3) begin
      acc3 = 1'b1;
      b = req_addr3[11:10];
      a = req_addr3[9:0];
      if (b >= 2'd3) begin
        chk("bank_en3_err", 64'(bank_en3), 64'd0);
        e.rdata = 32'd0; e.err = 1'b1; e.wr = 1'b0;
      end else begin
        chk("bank_en3", 64'(bank_en3), 64'(3'b001 << b));
        e.rdata = ref3[b][a]; e.err = 1'b0; e.wr = 1'b0;
      end
      q3.push_back(e);
    end else chk("bank_en3_idle", 64'(bank_en3), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [3:0] we, input logic [11:0] addr, input logic [31:0] wd);
    req_valid4 = v; req_we4 = we; req_addr4 = addr; req_wdata4 = wd;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q4.size() != 0 || q3.size() != 0); i++) tick();
    chk("drain4", 64'(q4.size()), 64'd0);
    chk("drain3", 64'(q3.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [11:0] bp_addr [4];
    bp_addr = '{12'h020, 12'h420, 12'h820, 12'hC20};
    for (int b = 0; b < 4; b++) for (int a = 0; a < 1024; a++) begin
      mem4[b][a] = init_val(b, a); ref4[b][a] = init_val(b, a);
      if (b < 3) begin mem3[b][a] = init_val(b, a); ref3[b][a] = init_val(b, a); end
    end
    drive4(1'b0, 4'h0, 12'h000, 32'h0);
    rsp_ready4 = 1'b1;
    req_valid3 = 1'b0; req_we3 = 4'h0; req_addr3 = 12'h000; req_wdata3 = 32'h0; rsp_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready4), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid4), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata4), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err4), 64'd0);
    chk("rst_rsp_write", 64'(rsp_write4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word write then read-back of the same address.
    drive4(1'b1, 4'hF, 12'h000, 32'hDEADBEEF);
    tick();
    chk("t1_wr_valid", 64'(rsp_valid4), 64'd1);
    chk("t1_wr_flag", 64'(rsp_write4), 64'd1);
    chk("t1_wr_rdata", 64'(rsp_rdata4), 64'd0);
    drive4(1'b1, 4'h0, 12'h000, 32'h0);
    tick();
    chk("t1_rd_valid", 64'(rsp_valid4), 64'd1);
    chk("t1_rd_flag", 64'(rsp_write4), 64'd0);
    chk("t1_rd_rdata", 64'(rsp_rdata4), 64'h0000_0000_DEAD_BEEF);
    drive4(1'b0, 4'h0, 12'h000, 32'h0);
    tick();

    // Byte-lane merge in bank 1.
    drive4(1'b1, 4'hF, 12'h401, 32'h11223344);
    tick();
    drive4(1'b1, 4'h2, 12'h401, 32'h0000AB00);
    tick();
    drive4(1'b1, 4'h0, 12'h401, 32'h0);
    tick();
    chk("t2_merge", 64'(rsp_rdata4), 64'h0000_0000_1122_AB44);
    drive4(1'b0, 4'h0, 12'h000, 32'h0);
    tick();

    // Out-of-range bank on the 3-bank instance, then an in-range read.
    req_valid3 = 1'b1; req_addr3 = 12'hC05;
    tick();
    chk("t3_err_valid", 64'(rsp_valid3), 64'd1);
    chk("t3_err_flag", 64'(rsp_err3), 64'd1);
    chk("t3_err_rdata", 64'(rsp_rdata3), 64'd0);
    req_addr3 = 12'h805;
    tick();
    chk("t3_ok_err", 64'(rsp_err3), 64'd0);
    chk("t3_ok_rdata", 64'(rsp_rdata3), 64'(init_val(2, 5)));
    req_valid3 = 1'b0;
    tick();
    drain();

    // Back-to-back reads across all banks.
    for (int i = 0; i < 8; i++) begin
      chk("t4_req_ready", 64'(req_ready4), 64'd1);
      drive4(1'b1, 4'h0, {2'(i % 4), 10'(16 + i / 4)}, 32'h0);
      tick();
      chk("t4_rsp_valid", 64'(rsp_valid4), 64'd1);
    end
    drive4(1'b0, 4'h0, 12'h000, 32'h0);
    drain();

    // Backpressure: only two requests fit until the consumer drains.
    rsp_ready4 = 1'b0;
    k = 0;
    drive4(1'b1, 4'h0, bp_addr[0], 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (acc4) begin
        k++;
        if (k < 4) req_addr4 = bp_addr[k]; else req_valid4 = 1'b0;
      end
    end
    chk("t5_accepted", 64'(k), 64'd2);
    chk("t5_ready_low", 64'(req_ready4), 64'd0);
    chk("t5_rsp_held", 64'(rsp_valid4), 64'd1);
    rsp_ready4 = 1'b1;
    for (int c = 0; c < 16 && k < 4; c++) begin
      tick();
      if (acc4) begin
        k++;
        if (k < 4) req_addr4 = bp_addr[k]; else req_valid4 = 1'b0;
      end
    end
    req_valid4 = 1'b0;
    chk("t5_all_accepted", 64'(k), 64'd4);
    drain();

    // Reset with one inflight and one skid entry pending.
    rsp_ready4 = 1'b0;
    drive4(1'b1, 4'h0, 12'h030, 32'h0);
    tick();
    drive4(1'b1, 4'h0, 12'h430, 32'h0);
    tick();
    drive4(1'b0, 4'h0, 12'h000, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_dropped", 64'(rsp_valid4), 64'd0);
    q4.delete();
    drive4(1'b1, 4'h0, 12'h030, 32'h0);
    #1;
    chk("t6_rst_bank_en", 64'(bank_en4), 64'd0);
    tick();
    drive4(1'b0, 4'h0, 12'h000, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready4 = 1'b1;
    chk("t6_no_stale", 64'(rsp_valid4), 64'd0);
    drive4(1'b1, 4'h0, 12'h430, 32'h0);
    tick();
    chk("t6_fresh_valid", 64'(rsp_valid4), 64'd1);
    chk("t6_fresh_rdata", 64'(rsp_rdata4), 64'(init_val(1, 48)));
    drive4(1'b0, 4'h0, 12'h000, 32'h0);
    tick();
    drain();
    chk("end_idle", 64'(rsp_valid4), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_banked_ctrl.md
Name: ram_banked_ctrl

Overview:
- Parametrised banked SRAM controller; successor to the fixed two-bank 8 KB wrapper.
- Tiles NUM_BANKS DFFRAM_4KB-style macros behind one valid/ready request/response port.
- Adds registered bank-select for the read mux, out-of-range error reporting, one response per request, and response backpressure through a 2-entry skid.
- Sits between the SoC bus adapter and the DFFRAM macros.

Parameters:
- NUM_BANKS, 4, number of macro banks (1..8; need not be a power of 2).
- BANK_AW, 10, word-address width of one bank (1024 words x 32 b = 4 KB).
- DW, 32, data width; byte lanes = DW/8.
- AW (localparam), BANK_AW + clog2(NUM_BANKS), request word-address width.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_we  in  DW/8  byte write enables; all-zero = read.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DW  read data (0 for writes and errors).
- rsp_err  out  1  request address was out of range.
- rsp_write  out  1  response belongs to a write.
- bank_en  out  NUM_BANKS  per-bank EN to macros.
- bank_we  out  DW/8  WE to all macros (gated by bank_en).
- bank_a  out  BANK_AW  address to all macros.
- bank_di  out  DW  write data to all macros.
- bank_do  in  NUM_BANKS*DW  concatenated macro outputs; bank i at [i*DW +: DW].

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, inflight empty, skid empty, rsp_rdata=0, rsp_err=0, rsp_write=0, req_ready=1.
- Accept: when req_valid && req_ready in cycle T.
  - bank = req_addr[AW-1:BANK_AW].
  - err = (bank >= NUM_BANKS).
  - bank_en is one-hot on bank in cycle T only, and all-zero if err.
  - bank_a = req_addr[BANK_AW-1:0] and bank_di = req_wdata, combinational.
  - bank_we = req_we when accepted, else 0.
  - No bank_en is asserted without an accepted request.
- Inflight register captures {bank, err, is_write} at the end of T.
- Cycle T+1, inflight item becomes the candidate response:
  - rdata = bank_do slice selected by the *registered* bank.
  - rdata forced to 0 if err or write.
- Output selection:
  - If skid is non-empty, rsp presents the skid head (older data).
  - Otherwise rsp presents the inflight item directly (read latency 1).
- If the inflight item is not handed off at T+1 (not presented, or rsp_ready=0), its full response, including rdata, is pushed into the skid at the end of T+1.
- Ordering: strictly in order; exactly one response per accepted request, including writes and errors.
- Occupancy = inflight_valid + skid_count.
  - req_ready = (occupancy < 2); registered-state only, no combinational path from rsp_ready.
  - Full throughput (1 req/cycle) when rsp_ready is held high.
  - Skid depth 2 guarantees capture without relying on macro output hold.
- Simultaneous push/pop on the skid: count unchanged, ordering preserved.
- Writes complete in the macro at the end of T; a read of the same address accepted at T+1 returns the new data.
- Reset mid-operation: pending responses are dropped, no bank_en is generated after reset assertion, and the first request after release behaves normally.

Decomposition:
- Package ram_banked_pkg holds:
  - rsp_t struct {rdata, err, write};
  - clog2 function;
  - bank-index extract helper.
- One sub-module, ram_rsp_skid: 2-entry FIFO of rsp_t with push/pop/count, async active-low reset.
- Macros are instantiated by the parent integration; this block drives their ports only.

Test Plan:
- Write 0xDEADBEEF, we=4'hF, to addr 0x000, then read 0x000 with rsp_ready=1 -> write rsp (rsp_write=1, rdata=0) at T+1; read rsp rdata=0xDEADBEEF at T+2; bank_en=4'b0001 both times.
- Byte write we=4'b0010, data 0x0000AB00, to addr 0x401, after 0x11223344 was written there -> read returns 0x1122AB44; bank_en=4'b0010.
- NUM_BANKS=3, read addr 0xC05 -> bank_en stays 0; rsp_err=1, rdata=0.
- Stream 8 reads to banks 0,1,2,3,0,1,2,3 with rsp_ready=1 -> req_ready stays 1; responses on consecutive cycles, in order, with correct per-bank data.
- Hold rsp_ready=0 while issuing 4 reads -> 2 accepted, then req_ready=0; release rsp_ready -> both returned in order with correct data; remaining 2 accepted afterwards.
- Assert RESETn=0 with 1 inflight and 1 skid entry -> rsp_valid=0 immediately; after release, a fresh read returns correct data with no stale response.
